// File: rtl/ula_seq_nbytes.sv
// rtl/ula_seq_nbytes.sv - byte-serial NBYTES-wide ALU sequencer around one 8-bit 74181-style ALU

module ula_8bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  input  logic       b_in,
  output logic [7:0] f,
  output logic       c_out,
  output logic       b_out,
  output logic       a_eq_b
);

  logic [7:0] t_or;
  logic [7:0] t_and;
  logic [8:0] sum;

  // 74181 active-high datapath: arithmetic = t_or + t_and + carry, then borrow decrement; logic = ~(t_or ^ t_and)
  always_comb begin
    t_or  = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
    t_and = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
    sum   = {1'b0, t_or} + {1'b0, t_and} + {8'd0, c_in};
    f     = ~(t_or ^ t_and);
    c_out = 1'b0;
    b_out = 1'b0;
    if (!m) begin
      f     = sum[7:0] - {7'd0, b_in};
      c_out = sum[8];
      b_out = b_in & (sum[7:0] == 8'd0);
    end
    a_eq_b = &f;
  end

endmodule

module ula_seq_nbytes #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  input  logic [3:0]            req_s,
  input  logic                  req_m,
  input  logic                  req_c_in,
  input  logic                  req_b_in,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_f,
  output logic                  rsp_c_out,
  output logic                  rsp_b_out,
  output logic                  rsp_a_eq_b,
  output logic                  busy
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state;
  state_t                     state_next;
  logic [IW-1:0]              idx;
  logic [NBYTES-1:0][7:0]     a_r;
  logic [NBYTES-1:0][7:0]     b_r;
  logic [NBYTES-1:0][7:0]     f_r;
  logic [3:0]                 s_r;
  logic                       m_r;
  logic                       carry_r;
  logic                       borrow_r;
  logic                       eq_acc;
  logic                       c_out_r;
  logic                       b_out_r;
  logic                       eq_out_r;
  logic                       busy_r;
  logic                       last_byte;
  logic [7:0]                 alu_f;
  logic                       alu_c;
  logic                       alu_b;
  logic                       alu_eq;

  assign last_byte = (idx == IW'(NBYTES - 1));

  ula_8bits u_alu (
    .a      (a_r[idx]),
    .b      (b_r[idx]),
    .s      (s_r),
    .m      (m_r),
    .c_in   (carry_r),
    .b_in   (borrow_r),
    .f      (alu_f),
    .c_out  (alu_c),
    .b_out  (alu_b),
    .a_eq_b (alu_eq)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state: accept in IDLE, one byte per cycle in RUN, hold result in DONE until taken
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = RUN;
      RUN:     if (last_byte) state_next = DONE;
      DONE:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy is a flop so it carries no combinational path from the handshake inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_r <= 1'b0;
    else        busy_r <= (state_next != IDLE);
  end

  // Operand latch on accept; per-byte result write and carry/borrow/equality chaining in RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      f_r      <= '0;
      s_r      <= '0;
      m_r      <= 1'b0;
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      eq_acc   <= 1'b0;
      c_out_r  <= 1'b0;
      b_out_r  <= 1'b0;
      eq_out_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_r      <= req_a;
            b_r      <= req_b;
            s_r      <= req_s;
            m_r      <= req_m;
            carry_r  <= req_c_in;
            borrow_r <= req_b_in;
            eq_acc   <= 1'b1;
            idx      <= '0;
          end
        end
        RUN: begin
          f_r[idx] <= alu_f;
          carry_r  <= alu_c;
          borrow_r <= alu_b;
          eq_acc   <= eq_acc & alu_eq;
          c_out_r  <= alu_c;
          b_out_r  <= alu_b;
          eq_out_r <= eq_acc & alu_eq;
          if (!last_byte) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign rsp_f      = f_r;
  assign rsp_c_out  = c_out_r;
  assign rsp_b_out  = b_out_r;
  assign rsp_a_eq_b = eq_out_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_ula_seq_nbytes.sv
// tb/tb_ula_seq_nbytes.sv - scoreboard testbench for ula_seq_nbytes

module tb_ula_seq_nbytes;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  typedef struct packed {
    logic [W-1:0] f;
    logic         c;
    logic         b;
    logic         eq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic [3:0]   req_s = '0;
  logic         req_m = 1'b0;
  logic         req_c_in = 1'b0;
  logic         req_b_in = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_f;
  logic         rsp_c_out;
  logic         rsp_b_out;
  logic         rsp_a_eq_b;
  logic         busy;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  ula_seq_nbytes #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_s      (req_s),
    .req_m      (req_m),
    .req_c_in   (req_c_in),
    .req_b_in   (req_b_in),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_f      (rsp_f),
    .rsp_c_out  (rsp_c_out),
    .rsp_b_out  (rsp_b_out),
    .rsp_a_eq_b (rsp_a_eq_b),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Full-width reference for the functions exercised here (74181 active-high table)
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                                 input logic m, input logic cin, input logic bin);
    exp_t       e;
    logic [W:0] sum;
    e = '0;
    if (m) begin
      if (s == 4'b0110) e.f = a ^ b;
      else              e.f = a;
    end else begin
      case (s)
        4'b1001: sum = {1'b0, a} + {1'b0, b}  + {{W{1'b0}}, cin};
        4'b0110: sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
        default: sum = {1'b0, a} + {{W{1'b0}}, cin};
      endcase
      e.c = sum[W];
      e.f = sum[W-1:0] - {{(W-1){1'b0}}, bin};
      e.b = bin && (sum[W-1:0] == '0);
    end
    e.eq = &e.f;
    return e;
  endfunction

  task automatic send_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin, input logic bin);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_req_ready actual=%b required=1", req_ready);
    end
    req_a = a; req_b = b; req_s = s; req_m = m; req_c_in = cin; req_b_in = bin;
    req_valid = 1'b1;
    exp_q.push_back(model(a, b, s, m, cin, bin));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a = ~a; req_b = ~b; req_s = ~s; req_c_in = ~cin; req_b_in = ~bin;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL send_busy actual=%b required=1", busy);
    end
  endtask

  task automatic wait_valid();
    int cyc;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || cyc != NB) begin
      failures++;
      $display("FAIL rsp_latency actual=%0d valid=%b required=%0d", cyc, rsp_valid, NB);
    end
  endtask

  task automatic check_rsp(input string name);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard actual=empty required=entry", name);
      return;
    end
    e = exp_q.pop_front();
    if (rsp_f !== e.f || rsp_c_out !== e.c || rsp_b_out !== e.b || rsp_a_eq_b !== e.eq) begin
      failures++;
      $display("FAIL %s actual f=%h c=%b b=%b eq=%b required f=%h c=%b b=%b eq=%b",
               name, rsp_f, rsp_c_out, rsp_b_out, rsp_a_eq_b, e.f, e.c, e.b, e.eq);
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL take_rsp actual valid=%b ready=%b busy=%b required 0 1 0", rsp_valid, req_ready, busy);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cin, input logic bin);
    send_req(a, b, s, m, cin, bin);
    wait_valid();
    check_rsp(name);
    take_rsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_f !== '0 ||
        rsp_c_out !== 1'b0 || rsp_b_out !== 1'b0 || rsp_a_eq_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_state actual rdy=%b vld=%b busy=%b f=%h c=%b b=%b eq=%b required 1 0 0 0 0 0 0",
               req_ready, rsp_valid, busy, rsp_f, rsp_c_out, rsp_b_out, rsp_a_eq_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_xor();
    run_op("xor", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0110, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_add();
    run_op("add_ripple", 32'h00FF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    run_op("add_overflow", 32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 1'b0);
    run_op("add_carry_in", 32'h0000_00FF, 32'h0000_0000, 4'b1001, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_equality();
    run_op("eq_equal", 32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'b0110, 1'b0, 1'b0, 1'b0);
    run_op("eq_differ", 32'h5B5A_5A5A, 32'h5A5A_5A5A, 4'b0110, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_borrow();
    run_op("borrow_chain", 32'h0000_0100, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_op("borrow_out", 32'h0000_0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] f_hold;
    logic         c_hold;
    logic         eq_hold;
    int           bad;
    send_req(32'h1234_5678, 32'h1111_1111, 4'b1001, 1'b0, 1'b0, 1'b0);
    wait_valid();
    check_rsp("bp_first");
    f_hold = rsp_f; c_hold = rsp_c_out; eq_hold = rsp_a_eq_b;
    req_a = 32'h0000_FFFF; req_b = 32'h0000_0001; req_s = 4'b1001; req_m = 1'b0;
    req_c_in = 1'b0; req_b_in = 1'b0;
    req_valid = 1'b1;
    exp_q.push_back(model(32'h0000_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 1'b0));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_f !== f_hold ||
          rsp_c_out !== c_hold || rsp_a_eq_b !== eq_hold || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold actual=%0d_bad_cycles required=0", bad);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_idle actual ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      failures++;
      $display("FAIL second_accept actual busy=%b ready=%b required 1 0", busy, req_ready);
    end
    wait_valid();
    check_rsp("bp_second");
    take_rsp();
  endtask

  task automatic test_reset_mid_run();
    send_req(32'h0102_0304, 32'h0101_0101, 4'b1001, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_f !== '0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_run actual busy=%b valid=%b f=%h ready=%b required 0 0 0 1",
               busy, rsp_valid, rsp_f, req_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset_add", 32'h00FF_00FF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_xor();
    test_add();
    test_equality();
    test_borrow();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
